// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: line and tick inputs, acknowledge, and the received word with status.
// master = line/consumer side, slave = the receiver.
interface uart_rx_cfg_if #(
  parameter int unsigned DATABITS = 8
);
  logic                STICK;
  logic                RX;
  logic                DACK;
  logic [DATABITS-1:0] DOUT;
  logic                VALID;
  logic                PARERR;
  logic                FRMERR;
  logic                OVERRUN;

  modport master (
    output STICK, RX, DACK,
    input  DOUT, VALID, PARERR, FRMERR, OVERRUN
  );

  modport slave (
    input  STICK, RX, DACK,
    output DOUT, VALID, PARERR, FRMERR, OVERRUN
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised RX, oversampled mid-bit sampling, start-glitch
// rejection, and a one-word holding register with parity/framing/overrun status.
module uart_rx_cfg #(
  parameter int unsigned DATABITS   = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOPBITS   = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic           CLOCK,
  input logic           RESET,
  uart_rx_cfg_if.slave  bus
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DATABITS);

  localparam logic [SW-1:0] SMid      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SLast     = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] NLast     = NW'(DATABITS - 1);
  localparam logic [NW-1:0] NStopLast = NW'(STOPBITS - 1);
  // Parity-check result that flags an error: 1 for even parity, 0 for odd.
  localparam logic          PErrRef   = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStrt, StData, StPrty, StStop} state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DATABITS-1:0] b_q, b_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [DATABITS-1:0] dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                parerr_q, parerr_d;
  logic                frmerr_q, frmerr_d;
  logic                overrun_q, overrun_d;
  logic                done;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    parerr_d  = parerr_q;
    frmerr_d  = frmerr_q;
    overrun_d = overrun_q;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStrt;
          s_d     = '0;
        end
      end
      StStrt: begin
        if (bus.STICK) begin
          if (s_q == SMid) begin
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (bus.STICK) begin
          if (s_q == SLast) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DATABITS-1:1]};
            if (n_q == NLast) begin
              state_d = (PARITY != 0) ? StPrty : StStop;
              n_d     = '0;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StPrty: begin
        if (bus.STICK) begin
          if (s_q == SLast) begin
            s_d     = '0;
            state_d = StStop;
            perr_d  = ((^b_q) ^ rx_s_q) == PErrRef;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (bus.STICK) begin
          if (s_q == SLast) begin
            if (!rx_s_q) ferr_d = 1'b1;
            if (n_q == NStopLast) begin
              done    = 1'b1;
              state_d = StIdle;
              n_d     = '0;
            end else begin
              s_d = '0;
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.DACK && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // A completion overrides the acknowledge; an ack in the same cycle just prevents overrun.
    if (done) begin
      dout_d   = b_q;
      parerr_d = perr_q;
      frmerr_d = ferr_d;
      valid_d  = 1'b1;
      if (valid_q && !bus.DACK) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      parerr_q  <= 1'b0;
      frmerr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= bus.RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      parerr_q  <= parerr_d;
      frmerr_q  <= frmerr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.DOUT    = dout_q;
  assign bus.VALID   = valid_q;
  assign bus.PARERR  = parerr_q;
  assign bus.FRMERR  = frmerr_q;
  assign bus.OVERRUN = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances share clock, tick and reset.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stick_v = 1'b0;
  int   phase = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATABITS(8)) if_a ();
  uart_rx_cfg_if #(.DATABITS(7)) if_b ();
  uart_rx_cfg_if #(.DATABITS(8)) if_c ();

  uart_rx_cfg u_dut_a (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (if_a)
  );

  uart_rx_cfg #(.DATABITS(7), .PARITY(2)) u_dut_b (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (if_b)
  );

  uart_rx_cfg #(.STOPBITS(2)) u_dut_c (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (if_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock step; the tick is high every fourth cycle.
  task automatic step();
    @(negedge clk);
    stick_v    = (phase == 0);
    if_a.STICK = stick_v;
    if_b.STICK = stick_v;
    if_c.STICK = stick_v;
    phase      = (phase + 1) % 4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: if_a.RX = v;
      1: if_b.RX = v;
      default: if_c.RX = v;
    endcase
  endtask

  task automatic set_dack(input int which, input logic v);
    case (which)
      0: if_a.DACK = v;
      1: if_b.DACK = v;
      default: if_c.DACK = v;
    endcase
  endtask

  task automatic ack(input int which);
    set_dack(which, 1'b1);
    step();
    set_dack(which, 1'b0);
  endtask

  // Bit period = 64 clocks. dack_done pulses DACK in the completion cycle, counted in ticks
  // from the STRT entry cycle (three clocks after RX falls). rst_mid pulses reset in data bit 4.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int has_par, input logic par_bit, input int nstop,
                            input logic stop2, input bit dack_done, input bit rst_mid);
    logic bits [12];
    int   nb;
    int   total;
    int   k;
    int   sc;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1 + i] = data[i];
    nb = 1 + nbits;
    if (has_par != 0) begin
      bits[nb] = par_bit;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (nstop == 2) begin
      bits[nb] = stop2;
      nb++;
    end
    total = 8 + 16 * (nbits + has_par + nstop);
    k  = 0;
    sc = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) begin
        step();
        if (j == 0) set_rx(which, bits[b]);
        if (b == nb - 1 && j == 40) set_rx(which, 1'b1);
        if (k >= 3 && stick_v) sc++;
        if (dack_done) set_dack(which, (k >= 3 && stick_v && sc == total));
        if (rst_mid && b == 5 && j == 0) begin
          rst = 1'b1;
          set_rx(which, 1'b1);
          step();
          rst = 1'b0;
          return;
        end
        k++;
      end
    end
  endtask

  initial begin
    if_a.RX = 1'b1; if_b.RX = 1'b1; if_c.RX = 1'b1;
    if_a.DACK = 1'b0; if_b.DACK = 1'b0; if_c.DACK = 1'b0;
    if_a.STICK = 1'b0; if_b.STICK = 1'b0; if_c.STICK = 1'b0;
    idle(8);
    rst = 1'b0;
    idle(4);
    check_eq("rst_dout", 32'(if_a.DOUT), 32'h0);
    check_eq("rst_valid", 32'(if_a.VALID), 32'h0);
    check_eq("rst_errs", {29'h0, if_a.PARERR, if_a.FRMERR, if_a.OVERRUN}, 32'h0);
    check_eq("rst_valid_b", 32'(if_b.VALID), 32'h0);

    // 8N1 basic frame and acknowledge
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check_eq("a5_dout", 32'(if_a.DOUT), 32'hA5);
    check_eq("a5_valid", 32'(if_a.VALID), 32'h1);
    check_eq("a5_errs", {29'h0, if_a.PARERR, if_a.FRMERR, if_a.OVERRUN}, 32'h0);
    ack(0);
    check_eq("a5_ack_valid", 32'(if_a.VALID), 32'h0);
    check_eq("a5_ack_dout_hold", 32'(if_a.DOUT), 32'hA5);

    // Start-bit glitch of 6 ticks is rejected
    idle(64);
    set_rx(0, 1'b0);
    idle(24);
    set_rx(0, 1'b1);
    idle(200);
    check_eq("glitch_valid", 32'(if_a.VALID), 32'h0);
    check_eq("glitch_dout", 32'(if_a.DOUT), 32'hA5);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check_eq("3c_dout", 32'(if_a.DOUT), 32'h3C);
    check_eq("3c_valid", 32'(if_a.VALID), 32'h1);
    ack(0);
    idle(100);

    // Back-to-back without ack -> overrun
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check_eq("ovr_dout", 32'(if_a.DOUT), 32'h22);
    check_eq("ovr_valid", 32'(if_a.VALID), 32'h1);
    check_eq("ovr_flag", 32'(if_a.OVERRUN), 32'h1);
    ack(0);
    check_eq("ovr_ack_valid", 32'(if_a.VALID), 32'h0);
    check_eq("ovr_ack_flag", 32'(if_a.OVERRUN), 32'h0);
    idle(100);

    // Ack in the second completion cycle -> no overrun, new word valid
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check_eq("cack_first_valid", 32'(if_a.VALID), 32'h1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    check_eq("cack_dout", 32'(if_a.DOUT), 32'h22);
    check_eq("cack_valid", 32'(if_a.VALID), 32'h1);
    check_eq("cack_overrun", 32'(if_a.OVERRUN), 32'h0);

    // 7E1: 0x55 has four ones; parity bit 1 makes five -> error
    send_frame(1, 9'h055, 7, 1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    check_eq("par1_dout", 32'(if_b.DOUT), 32'h55);
    check_eq("par1_perr", 32'(if_b.PARERR), 32'h1);
    check_eq("par1_ferr", 32'(if_b.FRMERR), 32'h0);
    ack(1);
    idle(100);
    send_frame(1, 9'h055, 7, 1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check_eq("par0_dout", 32'(if_b.DOUT), 32'h55);
    check_eq("par0_perr", 32'(if_b.PARERR), 32'h0);
    check_eq("par0_valid", 32'(if_b.VALID), 32'h1);
    ack(1);

    // 8N2: second stop bit low -> framing error, then a clean frame
    send_frame(2, 9'h081, 8, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    check_eq("frm_dout", 32'(if_c.DOUT), 32'h81);
    check_eq("frm_ferr", 32'(if_c.FRMERR), 32'h1);
    check_eq("frm_valid", 32'(if_c.VALID), 32'h1);
    ack(2);
    idle(200);
    send_frame(2, 9'h07E, 8, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    check_eq("frm_ok_dout", 32'(if_c.DOUT), 32'h7E);
    check_eq("frm_ok_ferr", 32'(if_c.FRMERR), 32'h0);
    check_eq("frm_ok_ovr", 32'(if_c.OVERRUN), 32'h0);

    // Reset mid-data aborts the frame (A still holds 0x22 with VALID=1)
    idle(100);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    check_eq("mrst_dout", 32'(if_a.DOUT), 32'h0);
    check_eq("mrst_valid", 32'(if_a.VALID), 32'h0);
    check_eq("mrst_errs", {29'h0, if_a.PARERR, if_a.FRMERR, if_a.OVERRUN}, 32'h0);
    idle(700);
    check_eq("mrst_no_valid", 32'(if_a.VALID), 32'h0);
    send_frame(0, 9'h0F0, 8, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check_eq("f0_dout", 32'(if_a.DOUT), 32'hF0);
    check_eq("f0_valid", 32'(if_a.VALID), 32'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It adds configurable data width, parity, stop-bit count and oversample factor, plus an RX input synchroniser and start-bit glitch rejection. It also provides a one-word holding register with valid/acknowledge handshake, and reports parity, framing and overrun errors. It sits between the pad-side RX line and the processor-side consumer, clocked by the system clock and paced by the oversample tick from the baud synchroniser.

## Interface
Parameters:
- DATABITS, 8, data bits per frame; legal 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOPBITS, 1, stop bits per frame; legal 1 or 2
- OVERSAMPLE, 16, STICK pulses per bit period; even, >= 4

Ports:
- CLOCK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- STICK  in  1  oversample tick; one-CLOCK-wide strobe, OVERSAMPLE per bit
- RX  in  1  serial line, asynchronous, idle high
- DACK  in  1  consumer acknowledge; clears VALID
- DOUT  out  DATABITS  received word, LSB = first data bit
- VALID  out  1  DOUT holds an unacknowledged word
- PARERR  out  1  parity error for word in DOUT (0 when PARITY=0)
- FRMERR  out  1  a stop bit sampled low for word in DOUT
- OVERRUN  out  1  sticky; a word was overwritten before DACK

## Operation
- RX passes through two flops (reset value 1) to give RX_S. All decisions use RX_S.
- Counters: S is clog2(OVERSAMPLE) bits wide, N is clog2(DATABITS) bits wide, B is the DATABITS-wide shift register. S advances only on cycles with STICK=1.
- IDLE: when RX_S=0, go to STRT with S=0.
- STRT: on STICK with S=OVERSAMPLE/2-1, check RX_S:
  - RX_S=0: go to DATA with S=0, N=0.
  - RX_S=1: glitch; return to IDLE with no output.
  - Otherwise S++.
- DATA: on STICK with S=OVERSAMPLE-1, set S=0 and B={RX_S, B[DATABITS-1:1]}.
  - If N=DATABITS-1, go to PRTY when PARITY!=0, else STOP.
  - Otherwise N++.
  - On other STICK cycles, S++.
- PRTY: on STICK with S=OVERSAMPLE-1, set S=0, go to STOP, and record perr = (^B ^ RX_S) == (PARITY==2 ? 1 : 0).
  - Odd: error when the total count of ones is even.
  - Even: error when the total count of ones is odd.
- STOP: on STICK with S=OVERSAMPLE-1, sample RX_S; any low sample sets ferr.
  - After the STOPBITS-th sample: complete the frame and go to IDLE.
  - Otherwise S=0, next stop bit.
  - Sampling is at mid-bit, so IDLE is re-entered half a bit early. This is intended: it allows immediate back-to-back frames.
- Completion: DOUT<=B, PARERR<=perr, FRMERR<=ferr, VALID<=1.
  - If VALID=1 and DACK=0 in the completion cycle, also set OVERRUN<=1.
- Handshake:
  - DACK with VALID=1 clears VALID and OVERRUN next cycle.
  - DACK with VALID=0 is ignored.
  - DACK in the completion cycle: the new word loads, VALID stays 1, OVERRUN is cleared.
- DOUT, PARERR and FRMERR hold until the next completion; they are not cleared by DACK.

## Timing
- Reset values:
  - DOUT=0, VALID=0, PARERR=0, FRMERR=0, OVERRUN=0.
  - State IDLE; S, N, B cleared.
  - Synchroniser flops set to 1.
- RESET asserted mid-frame aborts the frame: IDLE on the next edge with all outputs at reset values. No completion occurs.
- RX-to-RX_S latency: 2 CLOCKs.
- Frame completion to VALID high: 1 CLOCK. VALID rises on the edge after the STICK cycle that samples the last stop bit.
- Per-frame STICK count from the STRT entry cycle to completion: OVERSAMPLE/2 + OVERSAMPLE*(DATABITS + (PARITY!=0) + STOPBITS).
- STICK=0 cycles freeze S, N and the state, except the IDLE->STRT transition, which needs no STICK.
- RX is never sampled outside the mid-bit points listed above. Glitches shorter than OVERSAMPLE/2 ticks on the start bit are rejected.

## Test plan
- Defaults (8N1, OVERSAMPLE=16, STICK every 4 CLOCKs), send 0xA5 -> DOUT=0xA5, VALID=1, PARERR=FRMERR=OVERRUN=0; DACK one cycle -> VALID=0 next cycle.
- Drive RX low for 6 ticks, then high -> no VALID; the state returns to IDLE; a following 0x3C frame is received correctly.
- PARITY=2, DATABITS=7, send 0x55 with parity bit 1 -> DOUT=0x55, PARERR=1; repeat with parity bit 0 -> PARERR=0.
- STOPBITS=2, send 0x81 with the second stop bit low -> DOUT=0x81, FRMERR=1; next frame 0x7E with good stops -> FRMERR=0.
- Send 0x11 then 0x22 back-to-back with no DACK -> DOUT=0x22, VALID=1, OVERRUN=1; DACK -> VALID=0, OVERRUN=0. Repeat with DACK asserted exactly in the second completion cycle -> VALID=1, OVERRUN=0.
- Assert RESET for one cycle midway through the data bits -> all outputs at reset values next cycle, no VALID; a subsequent 0xF0 frame is received correctly.
